// File: rtl/sample_stream_arb_pkg.sv
// Shared types and constants for the sample stream arbiter.
package sample_stream_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int BEAT_CNT_W = 8;

endpackage

// File: rtl/sample_stream_arbiter_rr_priority_picker.sv
// Round-robin search: first set bit of valid at or after start, wrapping.
module rr_priority_picker
    import sample_stream_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   start,
    output logic [IDX_W-1:0]   index,
    output logic               found
);

    always_comb begin
        int pos;
        pos   = 0;
        index = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = (int'(start) + k) % NUM_REQ;
            if (!found && valid[pos]) begin
                index = IDX_W'(pos);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sample_stream_arbiter.sv
// Round-robin arbiter merging NUM_REQ beat streams onto one registered output stream.
//   state | meaning
//   IDLE  | no grant held; arbitrate among valid requesters
//   GRANT | grant_id owns the output until last beat or MAX_BURST beats
module sample_stream_arbiter
    import sample_stream_arb_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 8,
    parameter  int MAX_BURST  = 4,
    localparam int IDX_W      = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          out_valid,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_last,
    input  logic                          out_ready,
    output logic [IDX_W-1:0]              grant_id,
    output logic                          busy
);

    arb_state_t              state;
    arb_state_t              state_next;
    logic [IDX_W-1:0]        last_grant;
    logic [IDX_W-1:0]        start_idx;
    logic [IDX_W-1:0]        pick_idx;
    logic                    pick_found;
    logic [BEAT_CNT_W-1:0]   beat_cnt;
    logic                    xfer;
    logic                    release_grant;
    logic                    cur_valid;
    logic                    cur_last;
    logic [DATA_WIDTH-1:0]   cur_data;

    assign start_idx = (last_grant == IDX_W'(NUM_REQ - 1)) ? '0 : last_grant + IDX_W'(1);

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .valid (req_valid),
        .start (start_idx),
        .index (pick_idx),
        .found (pick_found)
    );

    assign cur_valid = req_valid[grant_id];
    assign cur_last  = req_last[grant_id];
    assign cur_data  = req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
    assign busy      = (state == GRANT);

    always_comb begin
        state_next    = state;
        req_ready     = '0;
        xfer          = 1'b0;
        release_grant = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found) state_next = GRANT;
            end
            GRANT: begin
                // The output register accepts a new beat when empty or draining this cycle.
                if (!rst) req_ready[grant_id] = !out_valid || out_ready;
                xfer          = !rst && (!out_valid || out_ready) && cur_valid;
                release_grant = xfer && (cur_last ||
                                (beat_cnt + BEAT_CNT_W'(1) == BEAT_CNT_W'(MAX_BURST)));
                if (release_grant) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            grant_id   <= '0;
            beat_cnt   <= '0;
            last_grant <= IDX_W'(NUM_REQ - 1);
        end else begin
            state <= state_next;
            if (state == IDLE && pick_found) begin
                grant_id <= pick_idx;
                beat_cnt <= '0;
            end
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= cur_data;
                out_last  <= cur_last;
                beat_cnt  <= beat_cnt + BEAT_CNT_W'(1);
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (release_grant) last_grant <= grant_id;
        end
    end

endmodule

// File: tb/tb_sample_stream_arbiter.sv
// Bench for sample_stream_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_sample_stream_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int MAXB = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic              out_last;
    logic              out_ready;
    logic [1:0]        grant_id;
    logic              busy;

    sample_stream_arbiter #(
        .NUM_REQ    (NREQ),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MAXB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    bit rand_mode = 1'b0;

    // Per-requester packet sources
    logic [DW-1:0] src_byte [NREQ];
    logic [3:0]    src_seq  [NREQ];
    int            src_rem  [NREQ];
    int            pkt_len  [NREQ];

    // Reference model: who owns the output, beats taken in this grant, registered beat
    bit            m_busy;
    int            m_owner;
    int            m_last;
    int            m_count;
    bit            m_ov;
    bit            m_ol;
    logic [DW-1:0] m_od;

    logic [DW-1:0] out_log[$];
    int            grant_log[$];
    bit            prev_busy = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] new_byte(input int i);
        if (rand_mode) return DW'($urandom);
        return {4'(i), src_seq[i]};
    endfunction

    task automatic src_reset();
        for (int i = 0; i < NREQ; i++) begin
            src_seq[i]  = '0;
            src_rem[i]  = pkt_len[i];
            src_byte[i] = new_byte(i);
        end
    endtask

    task automatic src_advance(input int i);
        src_seq[i] = src_seq[i] + 4'd1;
        src_rem[i] = src_rem[i] - 1;
        if (src_rem[i] == 0)
            src_rem[i] = rand_mode ? int'($urandom_range(1, 6)) : pkt_len[i];
        src_byte[i] = new_byte(i);
    endtask

    task automatic model_update(input bit r, input logic [NREQ-1:0] v, input bit ordy,
                                input logic [NREQ-1:0] exp_ready);
        bit found;
        int idx;
        if (r) begin
            m_busy = 0; m_owner = 0; m_last = NREQ - 1; m_count = 0;
            m_ov = 0; m_ol = 0; m_od = '0;
            return;
        end
        if (m_busy) begin
            if (exp_ready[m_owner] && v[m_owner]) begin
                m_od = req_data[m_owner*DW +: DW];
                m_ol = req_last[m_owner];
                m_ov = 1;
                m_count++;
                src_advance(m_owner);
                if (m_ol || m_count == MAXB) begin
                    m_busy = 0;
                    m_last = m_owner;
                end
            end else if (m_ov && ordy) begin
                m_ov = 0;
            end
        end else begin
            if (m_ov && ordy) m_ov = 0;
            found = 0;
            for (int k = 1; k <= NREQ; k++) begin
                idx = (m_last + k) % NREQ;
                if (!found && v[idx]) begin
                    found   = 1;
                    m_owner = idx;
                    m_count = 0;
                    m_busy  = 1;
                end
            end
        end
    endtask

    task automatic step(input bit r, input logic [NREQ-1:0] mask, input bit ordy);
        logic [NREQ-1:0] exp_ready;
        rst       = r;
        out_ready = ordy;
        req_valid = mask;
        for (int i = 0; i < NREQ; i++) begin
            req_data[i*DW +: DW] = src_byte[i];
            req_last[i]          = (src_rem[i] == 1);
        end
        @(negedge clk);
        exp_ready = '0;
        if (!r && m_busy && (!m_ov || ordy)) exp_ready[m_owner] = 1'b1;
        if (chk_en) begin
            chk("req_ready", req_ready, exp_ready);
            chk("out_valid", out_valid, m_ov);
            chk("busy", busy, m_busy);
            chk("grant_id", grant_id, m_owner);
            if (m_ov) begin
                chk("out_data", out_data, m_od);
                chk("out_last", out_last, m_ol);
            end
        end
        if (!r && out_valid && out_ready) out_log.push_back(out_data);
        if (busy && !prev_busy) grant_log.push_back(int'(grant_id));
        prev_busy = busy;
        model_update(r, mask, ordy, exp_ready);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_all();
        step(1'b1, '0, 1'b1);
        chk_en = 1'b1;
        step(1'b1, '0, 1'b1);
        src_reset();
        out_log.delete();
        grant_log.delete();
    endtask

    function automatic int gl(input int k);
        return (grant_log.size() > k) ? grant_log[k] : -1;
    endfunction

    function automatic int ol(input int k);
        return (out_log.size() > k) ? int'(out_log[k]) : -1;
    endfunction

    initial begin
        logic [DW-1:0] exp34 [12];
        exp34 = '{8'h00, 8'h01, 8'h02, 8'h20, 8'h21, 8'h22,
                  8'h03, 8'h04, 8'h05, 8'h23, 8'h24, 8'h25};

        // Two requesters, 3-beat packets: alternating grants with a dead cycle between
        for (int i = 0; i < NREQ; i++) pkt_len[i] = 3;
        reset_all();
        repeat (20) step(1'b0, 4'b0101, 1'b1);
        chk("s34_g0", gl(0), 0);
        chk("s34_g1", gl(1), 2);
        chk("s34_g2", gl(2), 0);
        chk("s34_g3", gl(3), 2);
        for (int k = 0; k < 12; k++) chk("s34_data", ol(k), int'(exp34[k]));

        // Long packet split by MAX_BURST, same requester re-granted
        pkt_len[0] = 10;
        reset_all();
        repeat (13) step(1'b0, 4'b0001, 1'b1);
        repeat (5) step(1'b0, 4'b0000, 1'b1);
        chk("s35_beats", out_log.size(), 10);
        chk("s35_grants", grant_log.size(), 3);
        for (int k = 0; k < 3; k++) chk("s35_gid", gl(k), 0);
        for (int k = 0; k < 10; k++) chk("s35_data", ol(k), k);

        // Output back-pressure holds the registered beat
        pkt_len[0] = 6;
        reset_all();
        step(1'b0, 4'b0001, 1'b1);
        step(1'b0, 4'b0001, 1'b1);
        for (int c = 0; c < 5; c++) begin
            step(1'b0, 4'b0001, 1'b0);
            chk("s36_valid", out_valid, 1'b1);
            chk("s36_data", out_data, 8'h00);
            chk("s36_ready", req_ready, 4'b0000);
        end
        repeat (10) step(1'b0, 4'b0001, 1'b1);
        for (int k = 0; k < 6; k++) chk("s36_out", ol(k), k);

        // Granted requester goes quiet; grant held, requester 1 locked out
        for (int i = 0; i < NREQ; i++) pkt_len[i] = 8;
        reset_all();
        step(1'b0, 4'b0011, 1'b1);
        step(1'b0, 4'b0011, 1'b1);
        for (int c = 0; c < 3; c++) begin
            step(1'b0, 4'b0010, 1'b1);
            chk("s37_busy", busy, 1'b1);
            chk("s37_gid", grant_id, 2'd0);
            chk("s37_rdy1", req_ready[1], 1'b0);
        end
        repeat (6) step(1'b0, 4'b0011, 1'b1);

        // Reset on the second beat of a burst
        reset_all();
        step(1'b0, 4'b0100, 1'b1);
        step(1'b0, 4'b0100, 1'b1);
        step(1'b1, 4'b0100, 1'b1);
        chk("s38_valid", out_valid, 1'b0);
        chk("s38_busy", busy, 1'b0);
        chk("s38_ready", req_ready, 4'b0000);
        grant_log.delete();
        repeat (4) step(1'b0, 4'b0110, 1'b1);
        chk("s38_first", gl(0), 1);

        // Everyone valid, single-beat packets: strict rotation
        for (int i = 0; i < NREQ; i++) pkt_len[i] = 1;
        reset_all();
        repeat (12) step(1'b0, 4'b1111, 1'b1);
        chk("s39_g0", gl(0), 0);
        chk("s39_g1", gl(1), 1);
        chk("s39_g2", gl(2), 2);
        chk("s39_g3", gl(3), 3);
        chk("s39_g4", gl(4), 0);

        // Randomized traffic, back-pressure and occasional reset
        rand_mode = 1'b1;
        for (int i = 0; i < NREQ; i++) pkt_len[i] = int'($urandom_range(1, 6));
        reset_all();
        for (int c = 0; c < 3000; c++) begin
            step(($urandom_range(0, 499) == 0), NREQ'($urandom),
                 ($urandom_range(0, 9) < 7));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
